exciter_channel_scheduler: RTL and testbench
============================================

# exciter_channel_scheduler

Round-robin scheduler that time-shares one harmonic-exciter datapath across `NUM_CH` audio channels. It sits between the per-channel sample sources and the single exciter core. It accepts samples through a valid/ready handshake and issues at most one sample per cycle to the core. It tags each in-flight sample and routes the core's result back to the originating channel's output register with a one-cycle valid pulse.

## Interface
- `NUM_CH`, 4: number of requesting channels; valid range 2–8.
- `DW`, 16: sample width; signed two's complement.
- `EX_LAT`, 2: fixed exciter-core latency in cycles, from the `ex_in` presentation cycle to the matching `ex_out` cycle; must be ≥1.
- `clk` in 1: sole clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_CH: per-channel sample-available flag.
- `req_sample` in NUM_CH*DW: per-channel samples; channel k occupies bits [k*DW +: DW].
- `req_ready` out NUM_CH: one-hot grant, combinational from `req_valid`, pointer, state and `hold`.
- `hold` in 1: when high, no new grant is issued; in-flight samples still complete.
- `ex_enable` out 1: registered; high in a cycle when `ex_in` carries an issued sample.
- `ex_in` out DW: registered sample to the exciter core.
- `ex_out` in DW: core result; sampled every cycle.
- `res_valid` out NUM_CH: registered one-cycle pulse per channel when `res_sample` for that channel updates.
- `res_sample` out NUM_CH*DW: per-channel result registers; each holds its value between updates.
- `busy` out 1: high when state is not IDLE.

## Operation
- A transfer occurs on channel k when `req_valid[k]` and `req_ready[k]` are both high at a rising edge.
- Grant rule: when `hold` is low, grant the first requesting channel at or after `ptr`, searching upward modulo NUM_CH. Grant nothing if no channel is requesting.
- After a grant to channel k, `ptr` becomes (k+1) mod NUM_CH. `ptr` is unchanged in cycles with no grant.
- When `hold` and a request are both high in the same cycle, `hold` wins: `req_ready` is all zero.
- On a transfer: `ex_in` is loaded with the sample and `ex_enable` is set to 1 in the next cycle; otherwise `ex_enable` is 0 and `ex_in` holds its value.
- Tag pipeline: EX_LAT+1 stages, each carrying {valid, channel index}. Stage 0 is aligned with `ex_enable`; the last stage is aligned with `ex_out`.
- When the last tag stage is valid with channel c: `res_sample[c]` is loaded with `ex_out` and `res_valid[c]` is 1 for one cycle.
- State machine:
  - IDLE → RUN on any transfer.
  - RUN → DRAIN when the cycle has no transfer and tags are still in flight.
  - DRAIN → RUN on a transfer.
  - RUN or DRAIN → IDLE when no transfer occurs and no tag is valid.
- Throughput is one sample per cycle. A single continuously requesting channel is granted every cycle.

## Timing
- A transfer at edge T produces `ex_enable`=1 after T. The matching `ex_out` is sampled at edge T+1+EX_LAT, and `res_valid` is high after edge T+1+EX_LAT. With the default EX_LAT=2, the result appears 3 cycles after the handshake edge.
- Reset values:
  - `ex_enable`=0, `ex_in`=0.
  - `res_valid`=0, `res_sample`=0 for all channels.
  - All tags invalid, `ptr`=0, state IDLE, `busy`=0.
  - `req_ready`=0 while `rst` is high.
- Reset asserted mid-operation discards all in-flight tags. No `res_valid` pulse is produced for them after release.
- Results for one channel return in issue order. Distinct channels may produce `res_valid` pulses in consecutive cycles.

## Configuration
- Macro: `EXCITER_BYPASS_EN`.
- Defined:
  - Adds input `bypass_mask` (NUM_CH bits).
  - Bypassed channels are arbitrated normally.
  - Their issue cycle drives `ex_enable`=0.
  - The dry sample travels in a parallel DW-wide delay line beside the tag, and `res_sample[c]` loads the dry sample instead of `ex_out`, with identical latency.
  - `bypass_mask` is sampled at the transfer edge.
- Undefined: the port is absent and every channel is processed by the core.

## Test plan
- Reset, then a single request on ch2 with sample 0x1234 and the core modelled as identity with EX_LAT=2: `req_ready`=0b0100 at the handshake edge, `ex_enable`=1 one cycle later, `res_valid[2]` pulses 3 cycles after the handshake, `res_sample[2]`=0x1234.
- All 4 channels requesting continuously for 8 cycles, ptr=0: grant order is 0,1,2,3,0,1,2,3 and results return in the same order on consecutive cycles.
- `hold`=1 while ch0 and ch1 request: no grant. In-flight results still complete, state goes DRAIN → IDLE, and `busy` drops. After `hold` is released, ch0 is granted first.
- Assert `rst` for 1 cycle with 2 samples in flight: no `res_valid` follows, all outputs are 0, `ptr`=0.
- With `EXCITER_BYPASS_EN`, `bypass_mask`=0b0010, ch1 sample 0x8000 and the core modelled to output 0x0000: `ex_enable` stays 0 for that slot and `res_sample[1]`=0x8000 at the normal latency.

Source files
------------

// File: rtl/exciter_channel_scheduler.sv
// Round-robin scheduler sharing one exciter core across NUM_CH channels, with a tag pipeline routing results back.
// Optional EXCITER_BYPASS_EN adds bypass_mask: bypassed channels skip the core and return the dry sample.
module exciter_channel_scheduler #(
  parameter int NUM_CH = 4,
  parameter int DW     = 16,
  parameter int EX_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    req_valid,
  input  logic [NUM_CH*DW-1:0] req_sample,
  output logic [NUM_CH-1:0]    req_ready,
  input  logic                 hold,
`ifdef EXCITER_BYPASS_EN
  input  logic [NUM_CH-1:0]    bypass_mask,
`endif
  output logic                 ex_enable,
  output logic [DW-1:0]        ex_in,
  input  logic [DW-1:0]        ex_out,
  output logic [NUM_CH-1:0]    res_valid,
  output logic [NUM_CH*DW-1:0] res_sample,
  output logic                 busy
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, stateNext;
  logic [PW-1:0] ptr;
  logic [PW-1:0] grantIdx;
  logic          grantAny;
  logic [PW-1:0] searchIdx;
  logic [DW-1:0] grantSample;
  logic          grantBypass;
  logic [DW-1:0] resultData;

  logic [EX_LAT:0] tagValid;
  logic [PW-1:0]   tagCh [EX_LAT+1];

  // First requester at or after ptr wins; hold and reset suppress every grant.
  always_comb begin
    req_ready = '0;
    grantIdx  = '0;
    grantAny  = 1'b0;
    searchIdx = '0;
    if (!rst && !hold) begin
      for (int i = 0; i < NUM_CH; i++) begin
        searchIdx = PW'((int'(ptr) + i) % NUM_CH);
        if (!grantAny && req_valid[searchIdx]) begin
          grantAny = 1'b1;
          grantIdx = searchIdx;
        end
      end
    end
    if (grantAny) req_ready[grantIdx] = 1'b1;
  end

  assign grantSample = req_sample[grantIdx*DW +: DW];

`ifdef EXCITER_BYPASS_EN
  logic          tagBypass [EX_LAT+1];
  logic [DW-1:0] tagDry    [EX_LAT+1];

  assign grantBypass = bypass_mask[grantIdx];
  assign resultData  = tagBypass[EX_LAT] ? tagDry[EX_LAT] : ex_out;

  // Dry samples ride alongside the tags so bypassed results keep the core's latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= EX_LAT; i++) begin
        tagBypass[i] <= 1'b0;
        tagDry[i]    <= '0;
      end
    end else begin
      tagBypass[0] <= grantAny && grantBypass;
      tagDry[0]    <= grantSample;
      for (int i = 1; i <= EX_LAT; i++) begin
        tagBypass[i] <= tagBypass[i-1];
        tagDry[i]    <= tagDry[i-1];
      end
    end
  end
`else
  assign grantBypass = 1'b0;
  assign resultData  = ex_out;
`endif

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:      if (grantAny) stateNext = RUN;
      RUN,
      DRAIN:     stateNext = grantAny ? RUN : ((|tagValid) ? DRAIN : IDLE);
      default:   stateNext = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Issue side: pointer advance, core input register and the tag pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      ex_enable <= 1'b0;
      ex_in     <= '0;
      tagValid  <= '0;
      for (int i = 0; i <= EX_LAT; i++) tagCh[i] <= '0;
    end else begin
      state     <= stateNext;
      ex_enable <= grantAny && !grantBypass;
      if (grantAny) begin
        ptr <= (grantIdx == PW'(NUM_CH - 1)) ? '0 : grantIdx + PW'(1);
        if (!grantBypass) ex_in <= grantSample;
      end
      tagValid <= {tagValid[EX_LAT-1:0], grantAny};
      tagCh[0] <= grantIdx;
      for (int i = 1; i <= EX_LAT; i++) tagCh[i] <= tagCh[i-1];
    end
  end

  // Return side: the last tag stage lines up with ex_out and selects the destination channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid  <= '0;
      res_sample <= '0;
    end else begin
      res_valid <= '0;
      if (tagValid[EX_LAT]) begin
        res_valid[tagCh[EX_LAT]]                <= 1'b1;
        res_sample[tagCh[EX_LAT]*DW +: DW]      <= resultData;
      end
    end
  end

endmodule

// File: tb/tb_exciter_channel_scheduler.sv
// Scoreboard bench for exciter_channel_scheduler: directed grants queue expected results, a monitor checks them.
// Exercises the EXCITER_BYPASS_EN path when that macro is defined.
module tb_exciter_channel_scheduler;

  localparam int NUM_CH = 4;
  localparam int DW     = 16;
  localparam int EX_LAT = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_CH-1:0]    req_valid;
  logic [NUM_CH*DW-1:0] req_sample;
  logic [NUM_CH-1:0]    req_ready;
  logic                 hold;
  logic [NUM_CH-1:0]    bypass_mask;
  logic                 ex_enable;
  logic [DW-1:0]        ex_in;
  logic [DW-1:0]        ex_out;
  logic [NUM_CH-1:0]    res_valid;
  logic [NUM_CH*DW-1:0] res_sample;
  logic                 busy;

  logic [DW-1:0] coreDly [EX_LAT] = '{default: '0};
  logic          coreZero = 1'b0;

  typedef struct {
    int          ch;
    logic [15:0] sample;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exciter_channel_scheduler #(.NUM_CH(NUM_CH), .DW(DW), .EX_LAT(EX_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_sample (req_sample),
    .req_ready  (req_ready),
    .hold       (hold),
`ifdef EXCITER_BYPASS_EN
    .bypass_mask(bypass_mask),
`endif
    .ex_enable  (ex_enable),
    .ex_in      (ex_in),
    .ex_out     (ex_out),
    .res_valid  (res_valid),
    .res_sample (res_sample),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Identity core model with EX_LAT cycles of latency, optionally forced to zero.
  always @(posedge clk) begin
    coreDly[0] <= ex_in;
    for (int i = 1; i < EX_LAT; i++) coreDly[i] <= coreDly[i-1];
  end
  assign ex_out = coreZero ? '0 : coreDly[EX_LAT-1];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Drives one cycle of inputs, checks the grant and queues the result the grant should produce.
  task automatic applyStimulus(input logic [3:0] v, input logic [63:0] s, input logic h,
                               input logic [3:0] expReady);
    exp_t e;
    @(negedge clk);
    req_valid  = v;
    req_sample = s;
    hold       = h;
    #1;
    checkOutput("req_ready", {60'd0, req_ready}, {60'd0, expReady});
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (expReady[ch]) begin
        e.ch     = ch;
        e.sample = s[ch*16 +: 16];
        e.due    = cyc + EX_LAT + 2;
        sb.push_back(e);
      end
    end
  endtask

  // Monitor: every res_valid pulse must match the oldest queued expectation, on time.
  always @(negedge clk) begin
    if (sb.size() > 0 && cyc > sb[0].due) begin
      checks++;
      failures++;
      $display("[TB] FAIL late_result: ch%0d missing at cycle %0d, required by cycle %0d",
               sb[0].ch, cyc, sb[0].due);
      void'(sb.pop_front());
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (res_valid[ch]) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_res_valid: ch%0d pulsed at cycle %0d, none required", ch, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("res_channel", 64'(ch), 64'(e.ch));
          checkOutput("res_sample", {48'd0, res_sample[ch*DW +: DW]}, {48'd0, e.sample});
          checkOutput("res_latency", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  initial begin
    logic [63:0] s;
    rst         = 1'b1;
    req_valid   = 4'b1111;
    req_sample  = '0;
    hold        = 1'b0;
    bypass_mask = '0;

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_req_ready", {60'd0, req_ready}, 64'd0);
    checkOutput("reset_ex_enable", {63'd0, ex_enable}, 64'd0);
    checkOutput("reset_ex_in", {48'd0, ex_in}, 64'd0);
    checkOutput("reset_res_valid", {60'd0, res_valid}, 64'd0);
    checkOutput("reset_res_sample", res_sample, 64'd0);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    rst       = 1'b0;
    req_valid = '0;

    $display("[TB] single request on ch2");
    applyStimulus(4'b0100, 64'h0000_1234_0000_0000, 1'b0, 4'b0100);
    applyStimulus(4'b0000, 64'd0, 1'b0, 4'b0000);
    checkOutput("single_ex_enable", {63'd0, ex_enable}, 64'd1);
    checkOutput("single_ex_in", {48'd0, ex_in}, 64'h1234);
    checkOutput("single_busy", {63'd0, busy}, 64'd1);
    repeat (6) applyStimulus(4'b0000, 64'd0, 1'b0, 4'b0000);
    checkOutput("single_res_hold", {48'd0, res_sample[2*DW +: DW]}, 64'h1234);

    $display("[TB] reset then all channels requesting");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      s = {16'hD000 + 16'(k), 16'hC000 + 16'(k), 16'hB000 + 16'(k), 16'hA000 + 16'(k)};
      applyStimulus(4'b1111, s, 1'b0, 4'(1 << (k % 4)));
    end

    $display("[TB] hold with requests pending");
    applyStimulus(4'b0100, 64'h0000_5555_0000_0000, 1'b0, 4'b0100);
    applyStimulus(4'b0011, 64'h0000_0000_2222_1111, 1'b1, 4'b0000);
    checkOutput("hold_busy_run", {63'd0, busy}, 64'd1);
    repeat (5) applyStimulus(4'b0011, 64'h0000_0000_2222_1111, 1'b1, 4'b0000);
    checkOutput("hold_busy_idle", {63'd0, busy}, 64'd0);
    applyStimulus(4'b0011, 64'h0000_0000_2222_1111, 1'b0, 4'b0001);
    applyStimulus(4'b0011, 64'h0000_0000_2222_1111, 1'b0, 4'b0010);
    repeat (5) applyStimulus(4'b0000, 64'd0, 1'b0, 4'b0000);

    $display("[TB] reset with two samples in flight");
    applyStimulus(4'b1000, 64'h7777_0000_0000_0000, 1'b0, 4'b1000);
    void'(sb.pop_back());
    applyStimulus(4'b0100, 64'h0000_6666_0000_0000, 1'b0, 4'b0100);
    void'(sb.pop_back());
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 4'b1111;
    #1;
    checkOutput("rst_req_ready", {60'd0, req_ready}, 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    #1;
    checkOutput("rst_ex_enable", {63'd0, ex_enable}, 64'd0);
    checkOutput("rst_ex_in", {48'd0, ex_in}, 64'd0);
    checkOutput("rst_res_sample", res_sample, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    repeat (5) applyStimulus(4'b0000, 64'd0, 1'b0, 4'b0000);
    applyStimulus(4'b1111, 64'h4444_3333_2222_0ABC, 1'b0, 4'b0001);
    repeat (5) applyStimulus(4'b0000, 64'd0, 1'b0, 4'b0000);

`ifdef EXCITER_BYPASS_EN
    $display("[TB] bypass on ch1");
    bypass_mask = 4'b0010;
    coreZero    = 1'b1;
    applyStimulus(4'b0010, 64'h0000_0000_8000_0000, 1'b0, 4'b0010);
    applyStimulus(4'b0000, 64'd0, 1'b0, 4'b0000);
    checkOutput("bypass_ex_enable", {63'd0, ex_enable}, 64'd0);
    repeat (5) applyStimulus(4'b0000, 64'd0, 1'b0, 4'b0000);
    checkOutput("bypass_res_sample", {48'd0, res_sample[1*DW +: DW]}, 64'h8000);
    coreZero    = 1'b0;
    bypass_mask = '0;
`endif

    repeat (8) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
